// File: rtl/tsp_pkg.sv
// Shared TSP datapath sizing and vector type for the SRF write path.
// Consumers: srf_write_arbiter, rr_arbiter (SRF_ARB_FIXED_PRIO_EN selects policy).
package tsp_pkg;

    localparam int TSP_NUM_STREAM_ID       = 5;
    localparam int TSP_MIN_VEC_LENGTH      = 16;
    localparam int TSP_NUM_TILES_PER_SLICE = 20;
    localparam int TSP_NUM_STREAMS         = 1 << TSP_NUM_STREAM_ID;

    typedef logic [TSP_MIN_VEC_LENGTH-1:0] elem_t;
    typedef elem_t [TSP_NUM_TILES_PER_SLICE-1:0] vec_t;
    typedef logic [TSP_NUM_STREAM_ID-1:0] stream_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection: round-robin from last_grant+1, or fixed
// priority (lowest index wins) when SRF_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import tsp_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant
);

`ifdef SRF_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic         found;
        int           idx;
        logic [W-1:0] sel;
        grant = '0;
        found = 1'b0;
        // Walk N slots starting just past the previous winner, wrapping.
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = idx[W-1:0];
            if (req[sel] && !found) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/srf_write_arbiter.sv
// Arbitrates requester writes into a single registered SRF write port.
// Policy is round-robin unless SRF_ARB_FIXED_PRIO_EN is defined.
module srf_write_arbiter
    import tsp_pkg::*;
#(
    parameter int NUM_REQ             = 3,
    parameter int NUM_STREAM_ID       = TSP_NUM_STREAM_ID,
    parameter int MIN_VEC_LENGTH      = TSP_MIN_VEC_LENGTH,
    parameter int NUM_TILES_PER_SLICE = TSP_NUM_TILES_PER_SLICE,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0] req_stream_id,
    input  logic [NUM_REQ-1:0][NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] req_data,
    output logic srf_write_enable,
    input  logic srf_ready,
    output logic [NUM_STREAM_ID-1:0] srf_stream_dest,
    output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] srf_write_data,
    output logic [IDX_W-1:0] grant_src,
    output logic conflict
);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic                     we_q;
    logic [NUM_STREAM_ID-1:0] dest_q;
    logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] data_q;
    logic [IDX_W-1:0]         src_q;
    logic [IDX_W-1:0]         last_q;
    logic                     conf_q;

    logic               load_ok;
    logic               xfer;
    logic               conflict_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gidx;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign load_ok   = !we_q || srf_ready;
    assign req_ready = load_ok ? grant : '0;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx = IDX_W'(i);
            end
        end
    end

    // Pairwise stream-ID compare over every valid request, granted or not.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (req_valid[i] && req_valid[j] &&
                    req_stream_id[i] == req_stream_id[j]) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
            src_q  <= '0;
            last_q <= LAST_RST;
            conf_q <= 1'b0;
        end else begin
            conf_q <= conflict_d;
            if (xfer) begin
                we_q   <= 1'b1;
                dest_q <= req_stream_id[gidx];
                data_q <= req_data[gidx];
                src_q  <= gidx;
                last_q <= gidx;
            end else if (srf_ready) begin
                we_q <= 1'b0;
            end
        end
    end

    assign srf_write_enable = we_q;
    assign srf_stream_dest  = dest_q;
    assign srf_write_data   = data_q;
    assign grant_src        = src_q;
    assign conflict         = conf_q;

endmodule

// File: tb/tb_srf_write_arbiter.sv
// Directed vector table plus hand sequences for srf_write_arbiter.
// Expectations switch with SRF_ARB_FIXED_PRIO_EN.
module tb_srf_write_arbiter;

    logic clk;
    logic rst;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [2:0][4:0] req_stream_id;
    logic [2:0][19:0][15:0] req_data;
    logic srf_write_enable;
    logic srf_ready;
    logic [4:0] srf_stream_dest;
    logic [19:0][15:0] srf_write_data;
    logic [1:0] grant_src;
    logic conflict;

    int tests;
    int fails;

    srf_write_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_stream_id    (req_stream_id),
        .req_data         (req_data),
        .srf_write_enable (srf_write_enable),
        .srf_ready        (srf_ready),
        .srf_stream_dest  (srf_stream_dest),
        .srf_write_data   (srf_write_data),
        .grant_src        (grant_src),
        .conflict         (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic        srdy;
        logic [4:0]  s0, s1, s2;
        logic [15:0] t0, t1, t2;
        logic [2:0]  rr;
        logic        we;
        logic [4:0]  dest;
        logic [15:0] tile;
        logic [1:0]  src;
        logic        conf;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(
        input logic [2:0] valid, input logic srdy,
        input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
        input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
        input logic [2:0] rr, input logic we, input logic [4:0] dest,
        input logic [15:0] tile, input logic [1:0] src, input logic conf);
        vec_t v;
        v.valid = valid; v.srdy = srdy;
        v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.t0 = t0; v.t1 = t1; v.t2 = t2;
        v.rr = rr; v.we = we; v.dest = dest;
        v.tile = tile; v.src = src; v.conf = conf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] val, input logic rdy,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [15:0] t0,
                         input logic [15:0] t1, input logic [15:0] t2);
        req_valid        = val;
        srf_ready        = rdy;
        req_stream_id[0] = s0;
        req_stream_id[1] = s1;
        req_stream_id[2] = s2;
        req_data[0]      = {20{t0}};
        req_data[1]      = {20{t1}};
        req_data[2]      = {20{t2}};
    endtask

    task automatic chk_out(input string tag, input logic we,
                           input logic [4:0] dest, input logic [15:0] tile,
                           input logic [1:0] src, input logic conf);
        chk({tag, ".we"}, 32'(srf_write_enable), 32'(we));
        chk({tag, ".dest"}, 32'(srf_stream_dest), 32'(dest));
        chk({tag, ".data0"}, 32'(srf_write_data[0]), 32'(tile));
        chk({tag, ".data19"}, 32'(srf_write_data[19]), 32'(tile));
        chk({tag, ".src"}, 32'(grant_src), 32'(src));
        chk({tag, ".conf"}, 32'(conflict), 32'(conf));
    endtask

    initial begin
        vec_t v;
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        drive(3'b000, 1'b1, 0, 0, 0, 0, 0, 0);

`ifdef SRF_ARB_FIXED_PRIO_EN
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,0, 0,16'h0000,0,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,0, 0,16'h0000,0,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b011,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b011,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b010,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b010,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,1, 2,16'h0A01,1,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,0, 2,16'h0A01,1,0));
`else
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,0, 0,16'h0000,0,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,0, 0,16'h0000,0,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b010,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b100,1, 2,16'h0A01,1,0));
        q.push_back(mk(3'b111,1, 1,2,3, 'hA00,'hA01,'hA02, 3'b001,1, 3,16'h0A02,2,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,1, 1,16'h0A00,0,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,0, 1,16'h0A00,0,0));
        q.push_back(mk(3'b010,1, 0,7,0, 0,'h1234,0,       3'b010,0, 1,16'h0A00,0,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,1, 7,16'h1234,1,0));
        q.push_back(mk(3'b111,1, 4,5,6, 'hB00,'hB01,'hB02, 3'b100,0, 7,16'h1234,1,0));
        for (int k = 0; k < 4; k++) begin
            q.push_back(mk(3'b111,0, 4,5,6, 'hB00,'hB01,'hB02, 3'b000,1, 6,16'h0B02,2,0));
        end
        q.push_back(mk(3'b111,1, 4,5,6, 'hB00,'hB01,'hB02, 3'b001,1, 6,16'h0B02,2,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,1, 4,16'h0B00,0,0));
        q.push_back(mk(3'b100,1, 0,0,9, 0,0,'h0009,       3'b100,0, 4,16'h0B00,0,0));
        q.push_back(mk(3'b101,1, 5,5,5, 'h5000,'h5001,'h5002, 3'b001,1, 9,16'h0009,2,0));
        q.push_back(mk(3'b100,1, 5,5,5, 'h5000,'h5001,'h5002, 3'b100,1, 5,16'h5000,0,1));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,1, 5,16'h5002,2,0));
        q.push_back(mk(3'b011,1, 1,2,0, 'hC00,'hC01,0,     3'b001,0, 5,16'h5002,2,0));
        q.push_back(mk(3'b011,1, 1,2,0, 'hC00,'hC01,0,     3'b010,1, 1,16'h0C00,0,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,1, 2,16'h0C01,1,0));
        q.push_back(mk(3'b000,1, 0,0,0, 0,0,0,           3'b000,0, 2,16'h0C01,1,0));
`endif

        @(negedge clk);
        #1;
        chk_out("reset", 1'b0, 5'd0, 16'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < q.size(); k++) begin
            v = q[k];
            if (k > 0) @(negedge clk);
            drive(v.valid, v.srdy, v.s0, v.s1, v.s2, v.t0, v.t1, v.t2);
            #1;
            chk($sformatf("v%0d.rr", k), 32'(req_ready), 32'(v.rr));
            chk_out($sformatf("v%0d", k), v.we, v.dest, v.tile, v.src, v.conf);
        end

        // Reset during a stall drops the held write; requester 0 wins after.
        @(negedge clk);
        drive(3'b111, 1'b1, 10, 11, 12, 'hD00, 'hD01, 'hD02);
        @(negedge clk);
        drive(3'b111, 1'b0, 10, 11, 12, 'hD00, 'hD01, 'hD02);
        #1;
        chk("stall.we", 32'(srf_write_enable), 32'd1);
        chk("stall.rr", 32'(req_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 5'd0, 16'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 1'b1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst.we", 32'(srf_write_enable), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst.we2", 32'(srf_write_enable), 32'd0);
        drive(3'b111, 1'b1, 10, 11, 12, 'hD00, 'hD01, 'hD02);
        #1;
        chk("post_rst.rr", 32'(req_ready), 32'b001);
        @(negedge clk);
        drive(3'b000, 1'b1, 0, 0, 0, 0, 0, 0);
        #1;
        chk_out("post_rst", 1'b1, 5'd10, 16'h0D00, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
